// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART stream receiver.
// Latency: n/a (package only).
// Backpressure: n/a. Optional parity support is enabled by UART_STREAM_RX_PARITY_EN.
package uart_pkg;

  // Receiver FSM states; PARITY exists only in parity-enabled builds.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_STREAM_RX_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } rx_state_t;

  // Clocks per sample tick: truncating division, never below one clock.
  function automatic int tick_div(input int clk_freq, input int baud, input int os);
    int d;
    d = clk_freq / (baud * os);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers for the receive path.
// Latency: push visible on empty/count/dout one clk after the write edge.
// Backpressure: push while full is dropped unless a pop occurs in the same cycle.
module rx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_dat,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_rd_ok;
  logic             w_wr_ok;

  // A pop frees the head slot, so a push into a full FIFO is legal when paired with a pop.
  assign w_rd_ok = i_pop & ~o_empty;
  assign w_wr_ok = i_push & (~o_full | w_rd_ok);

  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_empty = (o_count == '0);
  assign o_full  = (o_count == (AW+1)'(DEPTH));
  assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

  // Pointer update; the extra MSB distinguishes full from empty after wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_stream_rx.sv
// Oversampling UART receiver feeding a small FIFO; parity via UART_STREAM_RX_PARITY_EN.
// Latency: 2 clk synchronizer, byte pushed 1 clk after final stop sample, visible 1 clk later.
// Backpressure: none on the line; a byte arriving to a full FIFO is dropped and overrun pulses.
module uart_stream_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 10_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
`ifdef UART_STREAM_RX_PARITY_EN
  , parameter int PARITY_ODD = 0
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          dout,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun
`ifdef UART_STREAM_RX_PARITY_EN
  , output logic                        parity_err
`endif
);

  localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OS_W     = $clog2(OVERSAMPLE);
  localparam int BIT_W    = $clog2(DATA_BITS + 1);

  logic                 r_sync1, r_sync2, r_rx_prev;
  logic                 w_rx, w_fall, w_tick;
  logic [DIV_W-1:0]     r_div_cnt;
  rx_state_t            r_state;
  logic [OS_W-1:0]      r_os_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic                 r_stop_cnt;
  logic                 r_brk;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_push;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 w_full, w_empty;
`ifdef UART_STREAM_RX_PARITY_EN
  logic                 r_par;
  logic                 r_discard;
  logic                 r_parity_err;
`endif

  assign w_rx   = r_sync2;
  assign w_fall = r_rx_prev & ~w_rx;
  assign w_tick = (r_div_cnt == DIV_W'(TICK_DIV - 1));

  // Two-flop synchronizer plus edge history; idles high so reset never looks like a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= w_rx;
    end
  end

  // Sample-tick divider, re-phased to the start edge so mid-bit samples line up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               r_div_cnt <= '0;
    else if (r_state == ST_IDLE && w_fall) r_div_cnt <= '0;
    else if (w_tick)                       r_div_cnt <= '0;
    else                                   r_div_cnt <= r_div_cnt + 1'b1;
  end

  // Frame FSM with registered push and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_os_cnt    <= '0;
      r_bit_cnt   <= '0;
      r_stop_cnt  <= 1'b0;
      r_brk       <= 1'b0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_STREAM_RX_PARITY_EN
      r_par        <= 1'b0;
      r_discard    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_STREAM_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state  <= ST_START;
            r_os_cnt <= '0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (r_os_cnt == OS_W'(OVERSAMPLE/2 - 1)) begin
              r_os_cnt  <= '0;
              r_bit_cnt <= '0;
`ifdef UART_STREAM_RX_PARITY_EN
              r_par     <= 1'b0;
              r_discard <= 1'b0;
`endif
              // A line already back high at mid-start is a glitch, not a frame.
              r_state <= w_rx ? ST_IDLE : ST_DATA;
            end else begin
              r_os_cnt <= r_os_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_os_cnt == OS_W'(OVERSAMPLE - 1)) begin
              r_os_cnt <= '0;
              r_shift  <= {w_rx, r_shift[DATA_BITS-1:1]};
`ifdef UART_STREAM_RX_PARITY_EN
              r_par    <= r_par ^ w_rx;
`endif
              if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                r_stop_cnt <= 1'b0;
`ifdef UART_STREAM_RX_PARITY_EN
                r_state    <= ST_PARITY;
`else
                r_state    <= ST_STOP;
`endif
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_os_cnt <= r_os_cnt + 1'b1;
            end
          end
        end
`ifdef UART_STREAM_RX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            if (r_os_cnt == OS_W'(OVERSAMPLE - 1)) begin
              r_os_cnt <= '0;
              r_state  <= ST_STOP;
              if (w_rx != (r_par ^ 1'(PARITY_ODD))) begin
                r_parity_err <= 1'b1;
                r_discard    <= 1'b1;
              end
            end else begin
              r_os_cnt <= r_os_cnt + 1'b1;
            end
          end
        end
`endif
        ST_STOP: begin
          if (r_brk) begin
            // Hold off after a framing error until the line idles again.
            if (w_rx) begin
              r_brk   <= 1'b0;
              r_state <= ST_IDLE;
            end
          end else if (w_tick) begin
            if (r_os_cnt == OS_W'(OVERSAMPLE - 1)) begin
              r_os_cnt <= '0;
              if (!w_rx) begin
                r_frame_err <= 1'b1;
                r_brk       <= 1'b1;
              end else if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
`ifdef UART_STREAM_RX_PARITY_EN
                r_push  <= ~r_discard;
`else
                r_push  <= 1'b1;
`endif
                r_state <= ST_IDLE;
              end else begin
                r_stop_cnt <= 1'b1;
              end
            end else begin
              r_os_cnt <= r_os_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Overrun flags a completed byte that found no room and no concurrent pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_overrun <= 1'b0;
    else     r_overrun <= r_push & w_full & ~(rd_en & ~w_empty);
  end

  rx_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (r_push),
    .i_push_dat (r_shift),
    .i_pop      (rd_en),
    .o_dout     (dout),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_count    (count)
  );

  assign empty     = w_empty;
  assign full      = w_full;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
`ifdef UART_STREAM_RX_PARITY_EN
  assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_stream_rx.sv
// Scoreboard bench for uart_stream_rx: frames driven bit by bit, FIFO drained and compared.
// Latency: n/a.
// Backpressure: n/a. Parity checks build only with UART_STREAM_RX_PARITY_EN.
module tb_uart_stream_rx;

  localparam int BIT_CLKS = 80;   // 5 clk per tick * 16 ticks per bit

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] dout;
  logic       empty, full, frame_err, overrun;
  logic [3:0] count;
`ifdef UART_STREAM_RX_PARITY_EN
  logic       parity_err;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  int fe_cyc = 0;
  int ov_cyc = 0;
  int pe_cyc = 0;
  int fall_at;
  logic [7:0] exp_q[$];

  uart_stream_rx dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rd_en      (rd_en),
    .dout       (dout),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .frame_err  (frame_err),
    .overrun    (overrun)
`ifdef UART_STREAM_RX_PARITY_EN
    , .parity_err (parity_err)
`endif
  );

  always #50 clk = ~clk;

  // Pulse monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_err) fe_cyc++;
    if (overrun)   ov_cyc++;
`ifdef UART_STREAM_RX_PARITY_EN
    if (parity_err) pe_cyc++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    for (int c = 0; c < BIT_CLKS; c++) begin
      @(negedge clk);
      rx = b;
    end
  endtask

  // One frame; fall_c reports the stop-bit clock at which empty first dropped (-1 if never).
  task automatic send_frame(input logic [7:0] d, input logic stop_lvl,
                            input logic par_en, input logic par_bit, output int fall_c);
    logic was_empty;
    fall_c = -1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par_en) drive_bit(par_bit);
    was_empty = empty;
    for (int c = 0; c < BIT_CLKS; c++) begin
      @(negedge clk);
      if (was_empty && fall_c < 0 && !empty) fall_c = c;
      rx = stop_lvl;
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // Pop every scoreboard entry and compare against the FIFO head.
  task automatic drain(input string tag);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      chk({tag, "_nonempty"}, empty, 1'b0);
      chk({tag, "_dout"}, dout, e);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_empty_after"}, empty, 1'b1);
  endtask

  initial begin
    int fe0, ov0;
    // Reset values while rst is held.
    repeat (3) @(negedge clk);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 4'd0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    // Pop on empty is ignored.
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    @(negedge clk);
    chk("pop_empty_count", count, 4'd0);
    chk("pop_empty_empty", empty, 1'b1);
    idle(20);

    // Single byte 0xA5.
    fe0 = fe_cyc; ov0 = ov_cyc;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, fall_at);
    exp_q.push_back(8'hA5);
    chk("a5_fall_window", (fall_at >= 40 && fall_at <= 48), 1'b1);
    chk("a5_count", count, 4'd1);
    chk("a5_frame_err", fe_cyc - fe0, 0);
    chk("a5_overrun", ov_cyc - ov0, 0);
    drain("a5");

    // False start: two ticks low, then idle.
    fe0 = fe_cyc;
    for (int c = 0; c < 10; c++) begin @(negedge clk); rx = 1'b0; end
    idle(200);
    chk("false_count", count, 4'd0);
    chk("false_frame_err", fe_cyc - fe0, 0);

    // Framing error on 0x3C, then a good 0x11.
    fe0 = fe_cyc;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, fall_at);
    idle(40);
    chk("ferr_pulses", fe_cyc - fe0, 1);
    chk("ferr_count", count, 4'd0);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, fall_at);
    exp_q.push_back(8'h11);
    idle(4);
    chk("ferr_next_count", count, 4'd1);
    drain("b11");

    // Overflow: nine back-to-back bytes, no reads.
    ov0 = ov_cyc;
    for (int i = 0; i < 9; i++) begin
      send_frame(8'(i), 1'b1, 1'b0, 1'b0, fall_at);
      if (i < 8) exp_q.push_back(8'(i));
      if (i == 7) begin
        chk("ovf_full_8th", full, 1'b1);
        chk("ovf_count_8th", count, 4'd8);
        chk("ovf_no_overrun_yet", ov_cyc - ov0, 0);
      end
    end
    idle(4);
    chk("ovf_overrun_pulse", ov_cyc - ov0, 1);
    chk("ovf_count_9th", count, 4'd8);
    drain("ovf");

    // Reset mid-frame with two bytes queued.
    send_frame(8'h21, 1'b1, 1'b0, 1'b0, fall_at);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, fall_at);
    idle(4);
    chk("mid_count_pre", count, 4'd2);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    for (int c = 0; c < BIT_CLKS/2; c++) begin @(negedge clk); rx = 1'b1; end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_count", count, 4'd0);
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_dout", dout, 8'h00);
    rst = 1'b0;
    idle(200);
    chk("mid_post_count", count, 4'd0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, fall_at);
    exp_q.push_back(8'h5A);
    idle(4);
    drain("b5a");

`ifdef UART_STREAM_RX_PARITY_EN
    // Even parity on 0x07 (three ones) needs parity bit 1.
    begin
      int pe0 = pe_cyc;
      send_frame(8'h07, 1'b1, 1'b1, 1'b0, fall_at);
      idle(4);
      chk("par_bad_pulse", pe_cyc - pe0, 1);
      chk("par_bad_count", count, 4'd0);
      send_frame(8'h07, 1'b1, 1'b1, 1'b1, fall_at);
      exp_q.push_back(8'h07);
      idle(4);
      chk("par_good_pulse", pe_cyc - pe0, 1);
      drain("par");
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
